// File: rtl/ps2_key_decoder_pkg.sv
// ps2_key_decoder_pkg
//   Shared constants for the PS/2 key decoder slice: game key codes driven
//   on key[1:0], the scan-code set 2 bytes that matter to the game, and the
//   state encodings of the receiver and decoder state machines.
//   Also provides the frame validity helper used by the receiver.
package ps2_key_decoder_pkg;

  // Game key event codes
  localparam logic [1:0] K_NONE     = 2'b00;
  localparam logic [1:0] K_LEFT     = 2'b01;
  localparam logic [1:0] K_RIGHT    = 2'b10;
  localparam logic [1:0] K_SPACEBAR = 2'b11;

  // Scan-code set 2 bytes
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  // Receiver states
  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_SHIFT = 2'd1;
  localparam logic [1:0] RX_CHECK = 2'd2;

  // Decoder states
  localparam logic [1:0] D_IDLE    = 2'd0;
  localparam logic [1:0] D_EXT     = 2'd1;
  localparam logic [1:0] D_BRK     = 2'd2;
  localparam logic [1:0] D_EXT_BRK = 2'd3;

  // Frame layout in the shift register: [0]=start, [8:1]=data,
  // [9]=parity, [10]=stop. Parity covers data plus parity bit and must be odd.
  function automatic logic frame_ok(input logic [10:0] frame);
    return (frame[0] == 1'b0) && (frame[10] == 1'b1) && (^frame[9:1] == 1'b1);
  endfunction

endpackage

// File: rtl/ps2_key_decoder_rx.sv
// ps2_key_decoder_rx
//   PS/2 device-to-host frame receiver: synchronises both pins, glitch-filters
//   the PS/2 clock, shifts in 11 bits on filtered falling edges and checks
//   start/parity/stop. A frame stalled mid-way is dropped after a timeout.
// Ports
//   clk, rst           system clock, asynchronous active-high reset
//   ps2_clk, ps2_data  raw asynchronous PS/2 pins
//   data_byte[7:0]     received byte, valid while byte_valid is high
//   byte_valid         one-cycle pulse for a well-formed frame
//   frame_error        one-cycle pulse for a malformed or timed-out frame
module ps2_key_decoder_rx
  import ps2_key_decoder_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 130_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] data_byte,
  output logic       byte_valid,
  output logic       frame_error
);

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [FW-1:0] FILT_MAX = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYCLES - 1);

  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          clk_filt, clk_prev;
  logic [FW-1:0] filt_cnt;
  logic [1:0]    state;
  logic [3:0]    bit_cnt;
  logic [TW-1:0] to_cnt;
  logic [10:0]   sr;
  logic          fall, timeout;

  assign fall    = clk_prev & ~clk_filt;
  assign timeout = (state == RX_SHIFT) && !fall && (to_cnt == TO_MAX);

  assign data_byte   = sr[8:1];
  assign byte_valid  = (state == RX_CHECK) && frame_ok(sr);
  assign frame_error = ((state == RX_CHECK) && !frame_ok(sr)) || timeout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
      clk_filt <= 1'b1;
      clk_prev <= 1'b1;
      filt_cnt <= '0;
      state    <= RX_IDLE;
      bit_cnt  <= '0;
      to_cnt   <= '0;
    end else begin
      // Synchroniser stage
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;

      // Filter stage: a new level is accepted only after FILTER_LEN
      // consecutive samples disagree with the current filtered level.
      if (clk_s2 == clk_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FILT_MAX) begin
        clk_filt <= clk_s2;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
      clk_prev <= clk_filt;

      // Frame stage
      case (state)
        RX_IDLE: begin
          to_cnt <= '0;
          if (fall) begin
            bit_cnt <= 4'd1;
            state   <= RX_SHIFT;
          end
        end
        RX_SHIFT: begin
          if (fall) begin
            to_cnt <= '0;
            if (bit_cnt == 4'd10) state <= RX_CHECK;
            else                  bit_cnt <= bit_cnt + 1'b1;
          end else if (timeout) begin
            to_cnt <= '0;
            state  <= RX_IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

  // Data path: shift register carries no reset; its contents are only
  // interpreted after a complete 11-bit frame has been shifted in.
  always_ff @(posedge clk) begin
    if (fall && (state != RX_CHECK)) sr <= {dat_s2, sr[10:1]};
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder
//   Turns PS/2 scan-code set 2 traffic into game key events. Recognises
//   SPACE (29), LEFT (E0 6B) and RIGHT (E0 74); one event per physical press,
//   typematic repeats are suppressed by per-key held flags.
// Ports
//   clk, rst           system clock, asynchronous active-high reset
//   ps2_clk, ps2_data  raw asynchronous PS/2 pins (input only)
//   key[1:0]           K_NONE except for one cycle per accepted press
//   frame_error        one-cycle pulse on a malformed or timed-out frame
module ps2_key_decoder
  import ps2_key_decoder_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 130_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [1:0] key,
  output logic       frame_error
);

  logic [7:0] rx_byte;
  logic       rx_vld, rx_err;
  logic [1:0] dstate;
  logic       held_space, held_left, held_right;

  ps2_key_decoder_rx #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .data_byte  (rx_byte),
    .byte_valid (rx_vld),
    .frame_error(rx_err)
  );

  // Decode stage: prefix tracking, held flags and registered key event
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dstate      <= D_IDLE;
      held_space  <= 1'b0;
      held_left   <= 1'b0;
      held_right  <= 1'b0;
      key         <= K_NONE;
      frame_error <= 1'b0;
    end else begin
      key         <= K_NONE;
      frame_error <= rx_err;
      if (rx_err) begin
        // A lost byte may have been the one completing a prefix sequence
        dstate <= D_IDLE;
      end else if (rx_vld) begin
        case (dstate)
          D_IDLE: begin
            if (rx_byte == SC_EXT) begin
              dstate <= D_EXT;
            end else if (rx_byte == SC_BRK) begin
              dstate <= D_BRK;
            end else if (rx_byte == SC_SPACE && !held_space) begin
              held_space <= 1'b1;
              key        <= K_SPACEBAR;
            end
          end
          D_EXT: begin
            if (rx_byte == SC_BRK) begin
              dstate <= D_EXT_BRK;
            end else begin
              dstate <= D_IDLE;
              if (rx_byte == SC_LEFT && !held_left) begin
                held_left <= 1'b1;
                key       <= K_LEFT;
              end else if (rx_byte == SC_RIGHT && !held_right) begin
                held_right <= 1'b1;
                key        <= K_RIGHT;
              end
            end
          end
          D_BRK: begin
            if (rx_byte == SC_SPACE) held_space <= 1'b0;
            dstate <= D_IDLE;
          end
          default: begin
            if (rx_byte == SC_LEFT)  held_left  <= 1'b0;
            if (rx_byte == SC_RIGHT) held_right <= 1'b0;
            dstate <= D_IDLE;
          end
        endcase
      end
    end
  end

endmodule
